// File: rtl/kmer_candidate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : kmer_candidate_scheduler
// Brief    : Walks a signed read-position window, issues 4 k-mer candidates per
//            position to a shared lookup port and reports a per-position hit mask.
// Revision : 1.0 - initial release
// ============================================================================
module kmer_candidate_scheduler #(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int MAX_KMER_WIDTH     = 64
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          start,
    input  logic [MAX_READ_BIT_WIDTH:0]   cfgStartPos,
    input  logic [MAX_READ_BIT_WIDTH:0]   cfgEndPos,
    input  logic                          cfgDirection,
    input  logic [MAX_KMER_BIT_WIDTH-1:0] cfgKmerLength,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_READ_BIT_WIDTH:0]   position,
    output logic                          direction,
    output logic [MAX_KMER_BIT_WIDTH-1:0] kmerLength,
    input  logic [2*MAX_KMER_WIDTH-1:0]   kmerCandidate0,
    input  logic [2*MAX_KMER_WIDTH-1:0]   kmerCandidate1,
    input  logic [2*MAX_KMER_WIDTH-1:0]   kmerCandidate2,
    input  logic [2*MAX_KMER_WIDTH-1:0]   kmerCandidate3,
    output logic                          queryValid,
    input  logic                          queryReady,
    output logic [2*MAX_KMER_WIDTH-1:0]   queryKmer,
    output logic [1:0]                    queryTag,
    input  logic                          respValid,
    input  logic [1:0]                    respTag,
    input  logic                          respHit,
    output logic                          resultValid,
    input  logic                          resultReady,
    output logic [MAX_READ_BIT_WIDTH:0]   resultPosition,
    output logic [3:0]                    resultHitMask,
    output logic                          errDupResp
);

    localparam int c_POS_W  = MAX_READ_BIT_WIDTH + 1;
    localparam int c_KMER_W = 2 * MAX_KMER_WIDTH;
    localparam logic [c_POS_W-1:0] c_POS_ONE = {{(c_POS_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_next;

    logic [c_POS_W-1:0]            r_position;
    logic [c_POS_W-1:0]            r_end_pos;
    logic                          r_direction;
    logic [MAX_KMER_BIT_WIDTH-1:0] r_kmer_length;
    logic [1:0]                    r_issue_cnt;
    logic [3:0]                    r_rcv_mask;
    logic [3:0]                    r_hit_mask;
    logic                          r_err_dup;
    logic [c_POS_W-1:0]            r_result_pos;
    logic [3:0]                    r_result_mask;

    logic                          w_resp_fire;
    logic                          w_dup;
    logic [3:0]                    w_rcv_next;
    logic [3:0]                    w_hit_next;
    logic                          w_query_fire;
    logic                          w_last_issue;
    logic                          w_at_end;
    logic                          w_start_empty;
    logic                          w_result_fire;
    logic [c_KMER_W-1:0]           w_sel_kmer;

    // Responses are only meaningful while a position is in flight; late ones
    // arriving in IDLE/REPORT/FINISH are dropped.
    always_comb begin
        w_resp_fire   = respValid && ((r_state == S_ISSUE) || (r_state == S_WAIT));
        w_dup         = w_resp_fire && r_rcv_mask[respTag];
        w_rcv_next    = r_rcv_mask;
        w_hit_next    = r_hit_mask;
        if (w_resp_fire && !w_dup) begin
            w_rcv_next[respTag] = 1'b1;
            w_hit_next[respTag] = respHit;
        end
        w_query_fire  = (r_state == S_ISSUE) && queryReady;
        w_last_issue  = w_query_fire && (r_issue_cnt == 2'd3);
        w_at_end      = (r_position == r_end_pos);
        w_start_empty = ($signed(cfgStartPos) > $signed(cfgEndPos));
        w_result_fire = (r_state == S_REPORT) && resultReady;
    end

    always_comb begin
        w_sel_kmer = kmerCandidate0;
        case (r_issue_cnt)
            2'd0:    w_sel_kmer = kmerCandidate0;
            2'd1:    w_sel_kmer = kmerCandidate1;
            2'd2:    w_sel_kmer = kmerCandidate2;
            default: w_sel_kmer = kmerCandidate3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_start_empty ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_issue) begin
                    w_next = (w_rcv_next == 4'hF) ? S_REPORT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rcv_next == 4'hF) begin
                    w_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (resultReady) begin
                    w_next = w_at_end ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_position    <= '0;
            r_end_pos     <= '0;
            r_direction   <= 1'b0;
            r_kmer_length <= '0;
            r_issue_cnt   <= 2'd0;
            r_rcv_mask    <= 4'h0;
            r_hit_mask    <= 4'h0;
            r_err_dup     <= 1'b0;
            r_result_pos  <= '0;
            r_result_mask <= 4'h0;
        end else begin
            r_rcv_mask <= w_rcv_next;
            r_hit_mask <= w_hit_next;
            if (w_dup) begin
                r_err_dup <= 1'b1;
            end
            if (w_query_fire) begin
                r_issue_cnt <= r_issue_cnt + 2'd1;
            end
            // Result registers capture the final mask on REPORT entry so the
            // consumer sees values that cannot move until its handshake.
            if ((r_state != S_REPORT) && (w_next == S_REPORT)) begin
                r_result_pos  <= r_position;
                r_result_mask <= w_hit_next;
            end
            if (w_result_fire && !w_at_end) begin
                r_position  <= r_position + c_POS_ONE;
                r_issue_cnt <= 2'd0;
                r_rcv_mask  <= 4'h0;
                r_hit_mask  <= 4'h0;
            end
            if ((r_state == S_IDLE) && start) begin
                r_position    <= cfgStartPos;
                r_end_pos     <= cfgEndPos;
                r_direction   <= cfgDirection;
                r_kmer_length <= cfgKmerLength;
                r_issue_cnt   <= 2'd0;
                r_rcv_mask    <= 4'h0;
                r_hit_mask    <= 4'h0;
                r_err_dup     <= 1'b0;
            end
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);
    assign position       = r_position;
    assign direction      = r_direction;
    assign kmerLength     = r_kmer_length;
    assign queryValid     = (r_state == S_ISSUE);
    assign queryTag       = (r_state == S_ISSUE) ? r_issue_cnt : 2'd0;
    assign queryKmer      = (r_state == S_ISSUE) ? w_sel_kmer : '0;
    assign resultValid    = (r_state == S_REPORT);
    assign resultPosition = r_result_pos;
    assign resultHitMask  = r_result_mask;
    assign errDupResp     = r_err_dup;

endmodule
`default_nettype wire

// File: tb/tb_kmer_candidate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_kmer_candidate_scheduler
// Brief    : Directed self-checking bench for kmer_candidate_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kmer_candidate_scheduler;

    logic         clk = 1'b0;
    logic         rstb;
    logic         start;
    logic [8:0]   cfgStartPos;
    logic [8:0]   cfgEndPos;
    logic         cfgDirection;
    logic [5:0]   cfgKmerLength;
    logic         busy;
    logic         done;
    logic [8:0]   position;
    logic         direction;
    logic [5:0]   kmerLength;
    logic [127:0] kmerCandidate0;
    logic [127:0] kmerCandidate1;
    logic [127:0] kmerCandidate2;
    logic [127:0] kmerCandidate3;
    logic         queryValid;
    logic         queryReady;
    logic [127:0] queryKmer;
    logic [1:0]   queryTag;
    logic         respValid;
    logic [1:0]   respTag;
    logic         respHit;
    logic         resultValid;
    logic         resultReady;
    logic [8:0]   resultPosition;
    logic [3:0]   resultHitMask;
    logic         errDupResp;

    logic         auto_mode;
    logic [3:0]   auto_pat;
    logic         man_valid;
    logic [1:0]   man_tag;
    logic         man_hit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kmer_candidate_scheduler dut (
        .clk(clk), .rstb(rstb), .start(start),
        .cfgStartPos(cfgStartPos), .cfgEndPos(cfgEndPos),
        .cfgDirection(cfgDirection), .cfgKmerLength(cfgKmerLength),
        .busy(busy), .done(done), .position(position),
        .direction(direction), .kmerLength(kmerLength),
        .kmerCandidate0(kmerCandidate0), .kmerCandidate1(kmerCandidate1),
        .kmerCandidate2(kmerCandidate2), .kmerCandidate3(kmerCandidate3),
        .queryValid(queryValid), .queryReady(queryReady),
        .queryKmer(queryKmer), .queryTag(queryTag),
        .respValid(respValid), .respTag(respTag), .respHit(respHit),
        .resultValid(resultValid), .resultReady(resultReady),
        .resultPosition(resultPosition), .resultHitMask(resultHitMask),
        .errDupResp(errDupResp)
    );

    // Extractor model: each candidate encodes its index and the position.
    function automatic logic [127:0] cand(input logic [8:0] p, input logic [1:0] t);
        return {6'b110000, t, 111'b0, p};
    endfunction

    assign kmerCandidate0 = cand(position, 2'd0);
    assign kmerCandidate1 = cand(position, 2'd1);
    assign kmerCandidate2 = cand(position, 2'd2);
    assign kmerCandidate3 = cand(position, 2'd3);

    // Lookup model: either answers each accepted query in the same cycle or
    // is driven by hand for ordering and duplicate scenarios.
    assign respValid = auto_mode ? (queryValid & queryReady) : man_valid;
    assign respTag   = auto_mode ? queryTag : man_tag;
    assign respHit   = auto_mode ? auto_pat[queryTag] : man_hit;

    typedef struct {
        logic [8:0] sp;
        logic [8:0] ep;
        logic [3:0] pat;
        int         nres;
        logic       dir;
        logic [5:0] klen;
    } win_t;

    win_t wins[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {busy, done, position, direction, kmerLength, queryValid, queryKmer,
                 queryTag, resultValid, resultPosition, resultHitMask, errDupResp}, '0);
    endtask

    task automatic do_start(input logic [8:0] sp, input logic [8:0] ep,
                            input logic dir, input logic [5:0] klen);
        cfgStartPos   = sp;
        cfgEndPos     = ep;
        cfgDirection  = dir;
        cfgKmerLength = klen;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_result(input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (resultValid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("result_timeout", ok, 1'b1);
    endtask

    task automatic send_resp(input logic [1:0] t, input logic h);
        man_valid = 1'b1;
        man_tag   = t;
        man_hit   = h;
        tick();
        man_valid = 1'b0;
    endtask

    task automatic run_window(input win_t w);
        logic [8:0] exp_p;
        int n = 0, last = -10, dcyc = -1, busy_n = 0;
        bit got = 1'b0, saw_qv = 1'b0;
        auto_mode   = 1'b1;
        auto_pat    = w.pat;
        queryReady  = 1'b1;
        resultReady = 1'b1;
        exp_p       = w.sp;
        do_start(w.sp, w.ep, w.dir, w.klen);
        chk("cfg_fwd", {direction, kmerLength, errDupResp}, {w.dir, w.klen, 1'b0});
        for (int c = 0; c < 400; c++) begin
            if (busy) busy_n++;
            if (queryValid) begin
                saw_qv = 1'b1;
                chk("query_kmer", {position, queryKmer}, {exp_p, cand(exp_p, queryTag)});
            end
            if (resultValid) begin
                chk("result", {resultPosition, resultHitMask}, {exp_p, w.pat});
                last = c;
                n++;
                exp_p = exp_p + 9'd1;
            end
            if (done) begin
                got  = 1'b1;
                dcyc = c;
                break;
            end
            tick();
        end
        chk("done_seen", got, 1'b1);
        chk("result_count", n, w.nres);
        if (w.nres > 0) begin
            chk("done_latency", dcyc - last, 1);
        end else begin
            chk("empty_no_query", saw_qv, 1'b0);
            chk("empty_busy_cycles", busy_n, 1);
        end
        tick();
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        wins[0] = '{sp: -9'sd2,   ep: 9'sd1,     pat: 4'b0001, nres: 4, dir: 1'b0, klen: 6'd21};
        wins[1] = '{sp: 9'sd5,    ep: 9'sd3,     pat: 4'b0000, nres: 0, dir: 1'b1, klen: 6'd9};
        wins[2] = '{sp: 9'sd254,  ep: 9'sd255,   pat: 4'b1010, nres: 2, dir: 1'b1, klen: 6'd63};
        wins[3] = '{sp: -9'sd256, ep: -9'sd255,  pat: 4'b1111, nres: 2, dir: 1'b0, klen: 6'd1};
        wins[4] = '{sp: 9'sd0,    ep: 9'sd0,     pat: 4'b0000, nres: 1, dir: 1'b1, klen: 6'd31};
        wins[5] = '{sp: -9'sd1,   ep: -9'sd256,  pat: 4'b0101, nres: 0, dir: 1'b0, klen: 6'd5};

        rstb = 1'b0; start = 1'b0; cfgStartPos = '0; cfgEndPos = '0;
        cfgDirection = 1'b0; cfgKmerLength = '0; queryReady = 1'b0;
        resultReady = 1'b0; auto_mode = 1'b0; auto_pat = 4'h0;
        man_valid = 1'b0; man_tag = 2'd0; man_hit = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_window(wins[i]);
        end

        // Out-of-order responses; report must wait for the last one.
        auto_mode = 1'b0; queryReady = 1'b1; resultReady = 1'b1;
        do_start(9'd7, 9'd7, 1'b1, 6'd5);
        repeat (4) tick();
        chk("wait_state", {busy, queryValid, resultValid}, 3'b100);
        send_resp(2'd3, 1'b1);
        chk("early_report_1", resultValid, 1'b0);
        send_resp(2'd1, 1'b0);
        chk("early_report_2", resultValid, 1'b0);
        send_resp(2'd0, 1'b1);
        chk("early_report_3", resultValid, 1'b0);
        send_resp(2'd2, 1'b1);
        wait_result(3);
        chk("ooo_result", {resultPosition, resultHitMask}, {9'd7, 4'b1101});
        tick();
        chk("ooo_done", done, 1'b1);
        tick();

        // Query and result back-pressure.
        auto_mode = 1'b1; auto_pat = 4'b0110; queryReady = 1'b0; resultReady = 1'b0;
        do_start(9'd3, 9'd3, 1'b0, 6'd12);
        for (int k = 0; k < 4; k++) begin
            queryReady = 1'b0;
            tick();
            chk("stall_query", {queryValid, queryTag, queryKmer},
                {1'b1, 2'(k), cand(9'd3, 2'(k))});
            queryReady = 1'b1;
            tick();
        end
        queryReady = 1'b0;
        wait_result(5);
        for (int k = 0; k < 10; k++) begin
            chk("result_hold", {resultValid, resultPosition, resultHitMask}, {1'b1, 9'd3, 4'b0110});
            tick();
        end
        resultReady = 1'b1;
        tick();
        chk("stall_done", {done, resultValid}, 2'b10);
        tick();

        // Duplicate response: flagged, first answer kept, sticky across positions.
        auto_mode = 1'b0; queryReady = 1'b1; resultReady = 1'b1;
        do_start(9'd10, 9'd11, 1'b0, 6'd9);
        repeat (4) tick();
        send_resp(2'd2, 1'b0);
        chk("no_err_yet", errDupResp, 1'b0);
        send_resp(2'd2, 1'b1);
        chk("dup_err", errDupResp, 1'b1);
        send_resp(2'd0, 1'b1);
        send_resp(2'd1, 1'b0);
        send_resp(2'd3, 1'b0);
        wait_result(3);
        chk("dup_result", {resultPosition, resultHitMask}, {9'd10, 4'b0001});
        auto_mode = 1'b1; auto_pat = 4'b1000;
        tick();
        wait_result(20);
        chk("dup_next_pos", {resultPosition, resultHitMask, errDupResp}, {9'd11, 4'b1000, 1'b1});
        tick();
        chk("dup_done", done, 1'b1);
        tick();

        // Reset in WAIT, then a late response in IDLE, then a clean window.
        auto_mode = 1'b0;
        do_start(9'd20, 9'd21, 1'b1, 6'd1);
        chk("start_clears_err", errDupResp, 1'b0);
        repeat (4) tick();
        send_resp(2'd1, 1'b1);
        rstb = 1'b0;
        tick();
        chk_all_zero("mid_reset");
        rstb = 1'b1;
        send_resp(2'd0, 1'b1);
        chk_all_zero("late_resp_idle");
        run_window('{sp: 9'sd20, ep: 9'sd21, pat: 4'b0100, nres: 2, dir: 1'b1, klen: 6'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
